// File: rtl/ace_pkg.sv
// ace_pkg -- shared ACE snoop definitions.
// Purpose : snoop opcode constants, CRRESP layout, line-state update command,
//           default snoop channel structs, responder FSM states and the helper
//           functions that map a lookup result onto CRRESP and an update.
package ace_pkg;

  localparam int unsigned AceAddrWidth = 64;
  localparam int unsigned AceDataWidth = 64;

  typedef logic [3:0] acsnoop_t;

  localparam acsnoop_t AcReadOnce           = 4'b0000;
  localparam acsnoop_t AcReadShared         = 4'b0001;
  localparam acsnoop_t AcReadClean          = 4'b0010;
  localparam acsnoop_t AcReadNotSharedDirty = 4'b0011;
  localparam acsnoop_t AcReadUnique         = 4'b0111;
  localparam acsnoop_t AcCleanShared        = 4'b1000;
  localparam acsnoop_t AcCleanInvalid       = 4'b1001;
  localparam acsnoop_t AcMakeInvalid        = 4'b1101;

  // CRRESP[4:0] = {WasUnique, IsShared, PassDirty, Error, DataTransfer}
  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;

  typedef struct packed {
    logic invalidate;
    logic clear_dirty;
    logic clear_unique;
  } upd_cmd_t;

  typedef struct packed {
    logic [AceAddrWidth-1:0] addr;
    acsnoop_t                snoop;
    logic [2:0]              prot;
  } ace_ac_chan_t;

  typedef struct packed {
    logic         ac_valid;
    ace_ac_chan_t ac;
    logic         cr_ready;
    logic         cd_ready;
  } ace_snoop_req_t;

  typedef struct packed {
    logic [AceDataWidth-1:0] data;
    logic                    last;
  } ace_cd_chan_t;

  typedef struct packed {
    logic         ac_ready;
    logic         cr_valid;
    crresp_t      cr_resp;
    logic         cd_valid;
    ace_cd_chan_t cd;
  } ace_snoop_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WAIT_RES,
    SEND_CR,
    SEND_CD,
    UPDATE
  } snoop_state_e;

  // Error (lookup error or unknown opcode) dominates; otherwise a miss is all zero.
  function automatic crresp_t snoop_crresp(acsnoop_t snoop, logic hit, logic dirty,
                                           logic is_unique, logic err);
    crresp_t c;
    c = '0;
    if (err) begin
      c.error = 1'b1;
    end else begin
      case (snoop)
        AcReadOnce: begin
          c.data_transfer = hit;
          c.is_shared     = hit;
        end
        AcReadShared, AcReadClean, AcReadNotSharedDirty: begin
          c.data_transfer = hit;
          c.is_shared     = hit;
          c.pass_dirty    = hit & dirty;
          c.was_unique    = hit & is_unique;
        end
        AcReadUnique: begin
          c.data_transfer = hit;
          c.pass_dirty    = hit & dirty;
          c.was_unique    = hit & is_unique;
        end
        AcCleanInvalid, AcCleanShared: begin
          c.data_transfer = hit & dirty;
          c.pass_dirty    = hit & dirty;
        end
        AcMakeInvalid: c = '0;
        default:       c.error = 1'b1;
      endcase
    end
    return c;
  endfunction

  function automatic upd_cmd_t snoop_update(acsnoop_t snoop, logic hit, logic err);
    upd_cmd_t u;
    u = '0;
    if (hit && !err) begin
      case (snoop)
        AcReadUnique, AcCleanInvalid, AcMakeInvalid: u.invalidate = 1'b1;
        AcReadShared, AcReadClean, AcReadNotSharedDirty: begin
          u.clear_dirty  = 1'b1;
          u.clear_unique = 1'b1;
        end
        AcCleanShared: u.clear_dirty = 1'b1;
        default:       u = '0;
      endcase
    end
    return u;
  endfunction

endpackage

// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder -- answers ACE snoops from a local cache.
// Purpose : accepts one AC snoop at a time, performs a tag lookup, returns CR,
//           streams the line on CD when data is transferred, then issues a
//           line-state update when the snoop requires one.
// Ports   : clk_i/rst_ni           clock, asynchronous active-low reset
//           snoop_req_i            AC channel + CR/CD ready from interconnect
//           snoop_resp_o           AC ready + CR and CD channels
//           lookup_*               tag lookup request / result
//           data_req_o/data_gnt_i  per-beat line read, data_i valid with gnt
//           upd_*                  line-state update command handshake
module ace_snoop_responder
  import ace_pkg::*;
#(
  // Defaults to the 64-bit package structs so the block elaborates standalone.
  parameter type         snoop_req_t  = ace_snoop_req_t,
  parameter type         snoop_resp_t = ace_snoop_resp_t,
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned CdBeats      = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  snoop_req_t                 snoop_req_i,
  output snoop_resp_t                snoop_resp_o,
  output logic                       lookup_valid_o,
  input  logic                       lookup_ready_i,
  output logic [AddrWidth-1:0]       lookup_addr_o,
  input  logic                       lookup_rvalid_i,
  input  logic                       hit_i,
  input  logic                       dirty_i,
  input  logic                       unique_i,
  input  logic                       err_i,
  output logic                       data_req_o,
  input  logic                       data_gnt_i,
  output logic [$clog2(CdBeats)-1:0] data_beat_o,
  input  logic [DataWidth-1:0]       data_i,
  output logic                       upd_valid_o,
  input  logic                       upd_ready_i,
  output logic                       upd_invalidate_o,
  output logic                       upd_clear_dirty_o,
  output logic                       upd_clear_unique_o
);

  localparam int unsigned BeatW = $clog2(CdBeats);
  // One extra bit so the issue counter can reach CdBeats without wrapping.
  localparam logic [BeatW:0] NumBeats = (BeatW + 1)'(CdBeats);
  localparam logic [BeatW:0] LastBeat = (BeatW + 1)'(CdBeats - 1);

  snoop_state_e         r_state;
  logic [AddrWidth-1:0] r_addr;
  acsnoop_t             r_snoop;
  logic                 r_lookup_valid;
  logic                 r_cr_valid;
  crresp_t              r_cr_resp;
  upd_cmd_t             r_upd_cmd;
  logic                 r_upd_valid;
  logic [BeatW:0]       r_beat;
  logic                 r_cd_valid;
  logic [DataWidth-1:0] r_cd_data;
  logic                 r_cd_last;

  crresp_t  w_cr;
  upd_cmd_t w_upd;
  logic     w_cd_pop;
  logic     w_data_req;
  logic     w_data_fire;
  logic     w_unused;

  assign w_unused = ^snoop_req_i.ac.prot;

  assign w_cr  = snoop_crresp(r_snoop, hit_i, dirty_i, unique_i, err_i);
  assign w_upd = snoop_update(r_snoop, hit_i, err_i);

  // The CD register may be refilled in the same cycle it is popped, which
  // keeps the stream gap-free when grant and cd_ready are both held high.
  assign w_cd_pop    = r_cd_valid & snoop_req_i.cd_ready;
  assign w_data_req  = (r_state == SEND_CD) && (r_beat < NumBeats) &&
                       (!r_cd_valid || snoop_req_i.cd_ready);
  assign w_data_fire = w_data_req & data_gnt_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= IDLE;
      r_addr         <= '0;
      r_snoop        <= '0;
      r_lookup_valid <= 1'b0;
      r_cr_valid     <= 1'b0;
      r_cr_resp      <= '0;
      r_upd_cmd      <= '0;
      r_upd_valid    <= 1'b0;
      r_beat         <= '0;
      r_cd_valid     <= 1'b0;
      r_cd_data      <= '0;
      r_cd_last      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (snoop_req_i.ac_valid) begin
            r_addr         <= snoop_req_i.ac.addr;
            r_snoop        <= snoop_req_i.ac.snoop;
            r_lookup_valid <= 1'b1;
            r_state        <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lookup_ready_i) begin
            r_lookup_valid <= 1'b0;
            r_state        <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          // The lookup result is kept in its decoded form: CR plus update.
          if (lookup_rvalid_i) begin
            r_cr_resp  <= w_cr;
            r_upd_cmd  <= w_upd;
            r_cr_valid <= 1'b1;
            r_state    <= SEND_CR;
          end
        end
        SEND_CR: begin
          if (snoop_req_i.cr_ready) begin
            r_cr_valid <= 1'b0;
            if (r_cr_resp.data_transfer) begin
              r_beat  <= '0;
              r_state <= SEND_CD;
            end else if (|r_upd_cmd) begin
              r_upd_valid <= 1'b1;
              r_state     <= UPDATE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        SEND_CD: begin
          if (w_data_fire) begin
            r_cd_valid <= 1'b1;
            r_cd_data  <= data_i;
            r_cd_last  <= (r_beat == LastBeat);
            r_beat     <= r_beat + 1'b1;
          end else if (w_cd_pop) begin
            r_cd_valid <= 1'b0;
            r_cd_last  <= 1'b0;
          end
          if (w_cd_pop && r_cd_last) begin
            if (|r_upd_cmd) begin
              r_upd_valid <= 1'b1;
              r_state     <= UPDATE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        UPDATE: begin
          if (upd_ready_i) begin
            r_upd_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    snoop_resp_o          = '0;
    snoop_resp_o.ac_ready = (r_state == IDLE);
    snoop_resp_o.cr_valid = r_cr_valid;
    snoop_resp_o.cr_resp  = r_cr_resp;
    snoop_resp_o.cd_valid = r_cd_valid;
    snoop_resp_o.cd.data  = r_cd_data;
    snoop_resp_o.cd.last  = r_cd_last;
  end

  assign lookup_valid_o     = r_lookup_valid;
  assign lookup_addr_o      = r_addr;
  assign data_req_o         = w_data_req;
  assign data_beat_o        = r_beat[BeatW-1:0];
  assign upd_valid_o        = r_upd_valid;
  assign upd_invalidate_o   = r_upd_cmd.invalidate;
  assign upd_clear_dirty_o  = r_upd_cmd.clear_dirty;
  assign upd_clear_unique_o = r_upd_cmd.clear_unique;

endmodule
